// File: rtl/deskew_aligner.sv
// Re-aligns a lane-staggered word (lane i arrives i cycles after lane 0) into one output word.
// Latency: NUM_LANES-1 edges from lane-0 sample to valid_out (1 edge when NUM_LANES=1).
// No backpressure: accepts one word per cycle, delivers one word per cycle, never stalls.
module deskew_aligner #(
   parameter int LANE_BITS = 16,
   parameter int NUM_LANES = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_LANES-1:0]           valid_in,
   input  logic [NUM_LANES*LANE_BITS-1:0] data_in,
   output logic                           valid_out,
   output logic [NUM_LANES*LANE_BITS-1:0] data_out,
   output logic                           busy,
   output logic [15:0]                    word_count,
   output logic                           skew_error
);

   localparam int W = NUM_LANES * LANE_BITS;

   // vtap[k] = valid of the word whose lane 0 entered k cycles ago; vtap[0] is the live input
   logic [NUM_LANES-1:0] vtap;
   // lane taps after their complementary delay, ready for the output register
   logic [W-1:0]         aligned;
   logic                 load;
   logic                 mismatch;

   generate
      if (NUM_LANES > 1) begin : g_vpipe
         logic [NUM_LANES-1:1] vpipe;

         // Shift the lane-0 valid down the pipeline every cycle
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               vpipe <= '0;
            end else begin
               vpipe[1] <= valid_in[0];
               for (int k = 2; k < NUM_LANES; k++) begin
                  vpipe[k] <= vpipe[k-1];
               end
            end
         end

         assign vtap = {vpipe, valid_in[0]};
      end else begin : g_no_vpipe
         assign vtap = valid_in[0];
      end

      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         localparam int DLY = NUM_LANES - 1 - i;

         if (DLY == 0) begin : g_direct
            // The last lane arrives last, so it goes straight to the output register
            assign aligned[i*LANE_BITS +: LANE_BITS] = data_in[i*LANE_BITS +: LANE_BITS];
         end else begin : g_delay
            logic [LANE_BITS-1:0] sr [DLY];

            // Complementary delay line; shifts unconditionally so timing never depends on valid
            always_ff @(posedge clock or posedge reset) begin
               if (reset) begin
                  for (int k = 0; k < DLY; k++) begin
                     sr[k] <= '0;
                  end
               end else begin
                  sr[0] <= data_in[i*LANE_BITS +: LANE_BITS];
                  for (int k = 1; k < DLY; k++) begin
                     sr[k] <= sr[k-1];
                  end
               end
            end

            assign aligned[i*LANE_BITS +: LANE_BITS] = sr[DLY-1];
         end
      end
   endgenerate

   // Word completes when its lane-0 valid reaches the end of the pipeline
   assign load     = vtap[NUM_LANES-1];
   assign busy     = |vtap;
   // Bit 0 compares valid_in[0] with itself, so only lanes 1.. can flag a mismatch
   assign mismatch = |(valid_in ^ vtap);

   // Output register, delivered-word counter and sticky skew flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_out  <= 1'b0;
         data_out   <= '0;
         word_count <= '0;
         skew_error <= 1'b0;
      end else begin
         valid_out <= load;
         if (load) begin
            data_out <= aligned;
            if (word_count != 16'hFFFF) begin
               word_count <= word_count + 16'd1;
            end
         end
         if (mismatch) begin
            skew_error <= 1'b1;
         end
      end
   end

endmodule

// File: doc/deskew_aligner.md
# deskew_aligner

Receive-side counterpart of the input delay chains: the chains stagger a wide word so that lane i enters the array i cycles after lane 0. This block takes such a staggered stream and delays each lane by the complement amount, so that all NUM_LANES lanes of a word leave together in one registered, valid-tagged output word. It also tracks words in flight, counts delivered words and flags any lane whose valid does not follow the expected skew.

## Interface
- LANE_BITS, 16, width of one lane
- NUM_LANES, 4, number of lanes; legal range ≥ 1
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  NUM_LANES  per-lane valid; bit i qualifies lane i of data_in
- data_in  input  NUM_LANES*LANE_BITS  skewed lanes; lane i = bits [i*LANE_BITS +: LANE_BITS]
- valid_out  output  1  aligned word present on data_out this cycle
- data_out  output  NUM_LANES*LANE_BITS  aligned word, same lane packing as data_in
- busy  output  1  at least one word in flight inside the block
- word_count  output  16  number of words delivered, saturating
- skew_error  output  1  sticky; a lane valid did not match the expected skew

## Operation
- Word timing: valid_in[0] sampled high at edge t defines a word. Its lane i data and valid_in[i] are presented at edge t+i.
- Lane i passes through NUM_LANES-1-i delay registers, then the shared output register.
  - Lane NUM_LANES-1 feeds the output register directly.
  - Lane 0 passes through NUM_LANES-1 delay registers.
- Valid pipeline:
  - valid_in[0] passes through a NUM_LANES-1 stage shift register, vpipe[1..NUM_LANES-1].
  - vpipe[k] is the valid of the word whose lane 0 entered k cycles ago.
  - With NUM_LANES=1 the pipeline is empty.
- Output register:
  - Loads all lanes, and sets valid_out, only at an edge where the delayed lane-0 valid (vpipe[NUM_LANES-1], or valid_in[0] when NUM_LANES=1) is 1.
  - Otherwise valid_out is 0 and data_out holds its previous value.
  - Delay registers shift every cycle, regardless of valid.
- busy = OR of valid_in[0] and all vpipe bits, combinational.
- word_count: +1 at each edge that sets valid_out; saturates at 16'hFFFF and does not wrap.
- Skew check, evaluated at every edge:
  - For each i ≥ 1, the expected valid is vpipe[i] (valid_in[0] delayed i cycles).
  - If valid_in[i] ≠ vpipe[i], skew_error is set to 1 and stays 1 until reset.
  - The affected word is still delivered, with whatever data was on the lanes. Alignment is never adjusted.
- Back-to-back words (valid_in[0] high every cycle) give one valid_out per cycle with no bubbles. There is no backpressure.

## Timing
- Reset values: valid_out=0, data_out=0, busy=0, word_count=0, skew_error=0. All delay registers and vpipe are cleared.
- Reset is asynchronous. Asserting it mid-stream drops every in-flight word: no valid_out appears for words whose lane 0 entered before reset.
- First edge after reset release: valid_in is sampled normally.
- Latency: lane 0 sampled at edge t → valid_out=1 and the full word visible after edge t+NUM_LANES-1, for exactly one cycle if isolated.
- For NUM_LANES=1, latency is 1 edge: a single output register.
- word_count and valid_out update at the same edge.
- skew_error rises after the edge at which the mismatch is sampled.

## Test plan
1. NUM_LANES=4, LANE_BITS=16. Reset, then a single word: lane0=16'h1111 at edge 0, lane1=16'h2222 at edge 1, lane2=16'h3333 at edge 2, lane3=16'h4444 at edge 3, each with its valid bit. → After edge 3: valid_out=1, data_out=64'h4444_3333_2222_1111, word_count=1. Next cycle valid_out=0, data_out holds, busy=0, skew_error=0.
2. 100 back-to-back random skewed words. → valid_out high for 100 consecutive cycles starting after edge 3. Each word matches the scoreboard. word_count=100 after the last word.
3. Lane 2 valid dropped for one word (valid_in[2]=0 at edge t+2). → skew_error=1 after edge t+2 and stays 1. The word is still output at edge t+3. skew_error clears only on reset.
4. Reset asserted asynchronously mid-cycle while 3 words are in flight. → All outputs go to 0 immediately. No valid_out for those words after release. word_count=0.
5. word_count preset near saturation by streaming 65 537 words. → word_count stops at 16'hFFFF and does not wrap.
6. NUM_LANES=1 build: word on valid_in[0] at edge t. → valid_out=1 after edge t with data_out equal to data_in; busy equals valid_in[0].
